// File: rtl/morphle_sync_tx.sv
// rtl/morphle_sync_tx.sv - clocked transmitter serializing words into Morphle Logic 2-bit tokens
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   s_data/s_valid      word to send with its valid strobe
//   s_ready             registered; word accepted on an edge with s_valid & s_ready
//   tok                 registered token to the array (00 empty, 01 V0, 10 V1)
//   fb                  asynchronous token echoed back by the array
//   busy                high whenever the FSM is not idle
//   err, err_code       sticky error (01 mismatch, 10 illegal fb, 11 timeout)
//   err_clr             leaves the error state once fb has returned to empty

module morphle_sync_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [1:0]       tok,
  input  logic [1:0]       fb,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr
);

  localparam logic [1:0] TOK_E = 2'b00;
  localparam logic [1:0] TOK_0 = 2'b01;
  localparam logic [1:0] TOK_1 = 2'b10;
  localparam logic [1:0] TOK_X = 2'b11;

  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BITS     = BW'(WIDTH);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FULL, WAIT_EMPTY, ERR} state_t;

  state_t           state, state_d;
  logic [1:0]       tok_q, tok_d;
  logic             cur_bit, cur_bit_d;
  logic [WIDTH-1:0] sreg, sreg_d, sreg_sh;
  logic [BW-1:0]    bit_cnt, bit_cnt_d;
  logic [TW-1:0]    tmo_cnt, tmo_d;
  logic             s_ready_q, s_ready_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] fb_s;
  logic [1:0] val_tok, oth_tok;
  logic       first_bit, next_bit, tmo_hit, fail;
  logic [1:0] fail_code;

  // The chain resets to 11 (not empty) so s_ready only rises after a real
  // empty has propagated through every stage following reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= TOK_X;
    end else begin
      sync_q[0] <= fb;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign fb_s      = sync_q[SYNC_STAGES-1];
  assign val_tok   = cur_bit ? TOK_1 : TOK_0;
  assign oth_tok   = cur_bit ? TOK_0 : TOK_1;
  assign sreg_sh   = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
  assign first_bit = (LSB_FIRST != 0) ? s_data[0] : s_data[WIDTH-1];
  assign next_bit  = (LSB_FIRST != 0) ? sreg_sh[0] : sreg_sh[WIDTH-1];
  // Counter value TIMEOUT-1 means this edge is the TIMEOUT-th cycle waiting.
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tok_q     <= TOK_E;
      cur_bit   <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state     <= state_d;
      tok_q     <= tok_d;
      cur_bit   <= cur_bit_d;
      sreg      <= sreg_d;
      bit_cnt   <= bit_cnt_d;
      tmo_cnt   <= tmo_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state;
    tok_d     = tok_q;
    cur_bit_d = cur_bit;
    sreg_d    = sreg;
    bit_cnt_d = bit_cnt;
    err_d     = err_q;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = 2'b00;

    case (state)
      IDLE: begin
        if (s_valid && s_ready_q) begin
          sreg_d    = s_data;
          bit_cnt_d = BITS;
          cur_bit_d = first_bit;
          tok_d     = first_bit ? TOK_1 : TOK_0;
          state_d   = WAIT_FULL;
        end
      end
      WAIT_FULL: begin
        if (fb_s == TOK_X) begin
          fail = 1'b1; fail_code = 2'b10;
        end else if (fb_s == oth_tok) begin
          fail = 1'b1; fail_code = 2'b01;
        end else if (fb_s == val_tok) begin
          tok_d   = TOK_E;
          state_d = WAIT_EMPTY;
        end else if (tmo_hit) begin
          fail = 1'b1; fail_code = 2'b11;
        end
      end
      WAIT_EMPTY: begin
        // Echo of the value still present is normal; only the opposite value is wrong.
        if (fb_s == TOK_X) begin
          fail = 1'b1; fail_code = 2'b10;
        end else if (fb_s == oth_tok) begin
          fail = 1'b1; fail_code = 2'b01;
        end else if (fb_s == TOK_E) begin
          bit_cnt_d = bit_cnt - BW'(1);
          if (bit_cnt == BW'(1)) begin
            state_d = IDLE;
          end else begin
            sreg_d    = sreg_sh;
            cur_bit_d = next_bit;
            tok_d     = next_bit ? TOK_1 : TOK_0;
            state_d   = WAIT_FULL;
          end
        end else if (tmo_hit) begin
          fail = 1'b1; fail_code = 2'b11;
        end
      end
      ERR: begin
        if (err_clr && fb_s == TOK_E) begin
          err_d   = 1'b0;
          code_d  = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d   = ERR;
      tok_d     = TOK_E;
      err_d     = 1'b1;
      code_d    = fail_code;
      bit_cnt_d = '0;
    end

    tmo_d = (state == WAIT_FULL || state == WAIT_EMPTY) ? tmo_cnt + TW'(1) : '0;
    if (state_d != state) tmo_d = '0;

    s_ready_d = (state_d == IDLE) && (fb_s == TOK_E);
  end

  assign tok      = tok_q;
  assign s_ready  = s_ready_q;
  assign busy     = (state != IDLE);
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_morphle_sync_tx.sv
// tb/tb_morphle_sync_tx.sv - directed vector bench for morphle_sync_tx

module tb_morphle_sync_tx;

  logic       clk;
  logic       reset_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] tok;
  logic [1:0] fb;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr;
  logic       loop_en;
  logic [1:0] fb_force;

  logic [7:0] sd2;
  logic       sv2;
  logic       rdy10, busy10, err10, rdy0, busy0, err0;
  logic [1:0] tok10, code10, tok0, code0;
  logic [1:0] fb_idle;

  int n_chk;
  int n_bad;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;   // bits in send order, leftmost sent first
  } vec_t;

  vec_t vecs [6];

  assign fb      = loop_en ? tok : fb_force;
  assign fb_idle = 2'b00;

  morphle_sync_tx dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tok(tok), .fb(fb), .busy(busy), .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  morphle_sync_tx #(.TIMEOUT(10)) dut_t10 (
    .clk(clk), .reset_n(reset_n), .s_data(sd2), .s_valid(sv2), .s_ready(rdy10),
    .tok(tok10), .fb(fb_idle), .busy(busy10), .err(err10), .err_code(code10), .err_clr(1'b0)
  );

  morphle_sync_tx #(.TIMEOUT(0)) dut_t0 (
    .clk(clk), .reset_n(reset_n), .s_data(sd2), .s_valid(sv2), .s_ready(rdy0),
    .tok(tok0), .fb(fb_idle), .busy(busy0), .err(err0), .err_code(code0), .err_clr(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept_word(input logic [7:0] d);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept s_ready", 32'(s_ready), 1);
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = ~d;
  endtask

  // Samples after edges 0..47 of a word, then after edge 48.
  task automatic check_word(input logic [7:0] seq);
    int idx;
    logic [1:0] exp_tok;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      idx = k / 3;
      if (idx % 2 == 1) exp_tok = 2'b00;
      else exp_tok = seq[7 - idx/2] ? 2'b10 : 2'b01;
      chk($sformatf("tok cyc%0d", k), 32'(tok), 32'(exp_tok));
      chk($sformatf("s_ready low cyc%0d", k), 32'(s_ready), 0);
      chk($sformatf("busy cyc%0d", k), 32'(busy), 1);
    end
    @(negedge clk);
    chk("s_ready at 48", 32'(s_ready), 1);
    chk("busy at 48", 32'(busy), 0);
    chk("tok at 48", 32'(tok), 0);
    chk("err at 48", 32'(err), 0);
  endtask

  initial begin
    int n;
    n_chk    = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    s_data   = 8'h00;
    s_valid  = 1'b0;
    err_clr  = 1'b0;
    loop_en  = 1'b1;
    fb_force = 2'b00;
    sd2      = 8'h01;
    sv2      = 1'b0;

    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h3C, 8'b00111100};
    vecs[2] = '{8'h01, 8'b10000000};
    vecs[3] = '{8'h80, 8'b00000001};
    vecs[4] = '{8'h96, 8'b01101001};
    vecs[5] = '{8'hC5, 8'b10100011};

    // Reset state
    #1;
    chk("reset tok", 32'(tok), 0);
    chk("reset s_ready", 32'(s_ready), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset err", 32'(err), 0);
    chk("reset err_code", 32'(err_code), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Loopback words from the table
    for (int v = 0; v < 6; v++) begin
      accept_word(vecs[v].data);
      check_word(vecs[v].seq);
    end

    // Back-to-back 00 then FF with s_valid held high
    chk("b2b ready", 32'(s_ready), 1);
    s_data  = 8'h00;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_data = 8'hFF;
    check_word(8'h00);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'h5A;
    check_word(8'hFF);

    // Mismatch: fb=V0 while tok=V1
    loop_en  = 1'b0;
    fb_force = 2'b00;
    accept_word(8'h01);
    fb_force = 2'b01;
    repeat (3) @(negedge clk);
    chk("mismatch err early", 32'(err), 0);
    @(negedge clk);
    chk("mismatch err", 32'(err), 1);
    chk("mismatch code", 32'(err_code), 1);
    chk("mismatch tok", 32'(tok), 0);
    err_clr = 1'b1;
    repeat (5) @(negedge clk);
    chk("clr ignored err", 32'(err), 1);
    chk("clr ignored busy", 32'(busy), 1);
    chk("clr ignored s_ready", 32'(s_ready), 0);
    fb_force = 2'b00;
    n = 0;
    while (err !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("clr err", 32'(err), 0);
    chk("clr code", 32'(err_code), 0);
    chk("clr s_ready", 32'(s_ready), 1);
    chk("clr busy", 32'(busy), 0);
    err_clr = 1'b0;

    // Illegal fb during WAIT_EMPTY
    loop_en = 1'b1;
    accept_word(8'h01);
    repeat (4) @(negedge clk);
    chk("illegal pre tok", 32'(tok), 0);
    loop_en  = 1'b0;
    fb_force = 2'b11;
    repeat (2) @(negedge clk);
    chk("illegal err early", 32'(err), 0);
    @(negedge clk);
    chk("illegal err", 32'(err), 1);
    chk("illegal code", 32'(err_code), 2);
    chk("illegal tok", 32'(tok), 0);
    fb_force = 2'b00;
    err_clr  = 1'b1;
    n = 0;
    while (err !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("illegal clr err", 32'(err), 0);
    chk("illegal clr s_ready", 32'(s_ready), 1);
    err_clr = 1'b0;
    loop_en = 1'b1;

    // Timeout: TIMEOUT=10 errors on the 10th edge, TIMEOUT=0 never does
    chk("t10 ready", 32'(rdy10), 1);
    chk("t0 ready", 32'(rdy0), 1);
    sv2 = 1'b1;
    @(posedge clk);
    #1;
    sv2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t10 err at 9", 32'(err10), 0);
    chk("t10 busy at 9", 32'(busy10), 1);
    @(negedge clk);
    chk("t10 err at 10", 32'(err10), 1);
    chk("t10 code", 32'(code10), 3);
    chk("t10 tok", 32'(tok10), 0);
    repeat (1000) @(negedge clk);
    chk("t0 err", 32'(err0), 0);
    chk("t0 code", 32'(code0), 0);
    chk("t0 busy", 32'(busy0), 1);
    chk("t0 tok", 32'(tok0), 2);

    // Asynchronous reset in the middle of bit 3 of A5
    accept_word(8'hA5);
    repeat (20) @(negedge clk);
    chk("pre-reset tok", 32'(tok), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset tok", 32'(tok), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset s_ready", 32'(s_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset s_ready edge2", 32'(s_ready), 0);
    @(negedge clk);
    chk("post-reset s_ready edge3", 32'(s_ready), 1);
    accept_word(8'h3C);
    check_word(8'b00111100);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
